// File: rtl/bcd_to_binary_if.sv
// rtl/bcd_to_binary_if.sv - Start/Busy/Done handshake plus digit and result bundle for bcd_to_binary
interface bcd_to_binary_if #(
  parameter int OUT_WIDTH = 10
);
  logic                 Start;
  logic [3:0]           Dig1;
  logic [3:0]           Dig2;
  logic [3:0]           Dig3;
  logic                 Busy;
  logic                 Done;
  logic [OUT_WIDTH-1:0] Binary;
  logic                 Error;

  modport master (
    output Start, Dig1, Dig2, Dig3,
    input  Busy, Done, Binary, Error
  );

  modport slave (
    input  Start, Dig1, Dig2, Dig3,
    output Busy, Done, Binary, Error
  );
endinterface

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - 3-digit BCD to binary converter, one shared x10 accumulator, 3-cycle conversion
// Optional digit range check: define BCD_TO_BINARY_DIGIT_CHECK_EN.
module bcd_to_binary #(
  parameter int OUT_WIDTH = 10
) (
  input  logic           Clock,
  input  logic           Reset,
  bcd_to_binary_if.slave bus
);

  localparam int ACC_W = 11;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     acc_next;
  logic [3:0]           dig1_q, dig1_d;
  logic [3:0]           dig2_q, dig2_d;
  logic [3:0]           dig3_q, dig3_d;
  logic [3:0]           digit_sel;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [OUT_WIDTH-1:0] binary_q, binary_d;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
  logic                 invalid_q, invalid_d;
  logic                 error_q, error_d;
`endif

  // Most significant digit first so the x10 accumulator weights it by 100.
  always_comb begin
    digit_sel = 4'd0;
    case (step_q)
      2'd0:    digit_sel = dig3_q;
      2'd1:    digit_sel = dig2_q;
      2'd2:    digit_sel = dig1_q;
      default: digit_sel = 4'd0;
    endcase
  end

  assign acc_next = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, digit_sel};

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    dig1_d   = dig1_q;
    dig2_d   = dig2_q;
    dig3_d   = dig3_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    binary_d = binary_q;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    invalid_d = invalid_q;
    error_d   = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          dig1_d  = bus.Dig1;
          dig2_d  = bus.Dig2;
          dig3_d  = bus.Dig3;
          acc_d   = '0;
          step_d  = 2'd0;
          busy_d  = 1'b1;
          state_d = CONV;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
          invalid_d = (bus.Dig1 > 4'd9) | (bus.Dig2 > 4'd9) | (bus.Dig3 > 4'd9);
`endif
        end
      end
      CONV: begin
        acc_d = acc_next;
        if (step_q == 2'd2) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
          binary_d = invalid_q ? '0 : OUT_WIDTH'(acc_next);
          error_d  = invalid_q;
`else
          binary_d = OUT_WIDTH'(acc_next);
`endif
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      acc_q    <= '0;
      dig1_q   <= 4'd0;
      dig2_q   <= 4'd0;
      dig3_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      binary_q <= '0;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
      invalid_q <= 1'b0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      dig1_q   <= dig1_d;
      dig2_q   <= dig2_d;
      dig3_q   <= dig3_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      binary_q <= binary_d;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
      invalid_q <= invalid_d;
      error_q   <= error_d;
`endif
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Binary = binary_q;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
  assign bus.Error  = error_q;
`else
  assign bus.Error  = 1'b0;
`endif

endmodule
